// File: rtl/jump_controller_pkg.sv
// Shared types and helpers for the jump controller: FSM states, side
// encodings, counter widths and the Galois LFSR step function.
package jump_controller_pkg;

  typedef enum logic [1:0] {
    S_WAIT_KEY = 2'd0,
    S_JUMP     = 2'd1,
    S_FALL     = 2'd2,
    S_OVER     = 2'd3
  } jc_state_t;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  localparam int SCORE_W = 14;
  localparam int PRESC_W = 17;
  localparam int MS_W    = 11;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    logic [15:0] shifted;
    shifted = {1'b0, q[15:1]};
    if (q[0]) begin
      lfsr_step = shifted ^ LFSR_TAPS;
    end else begin
      lfsr_step = shifted;
    end
  endfunction

endpackage

// File: rtl/jump_controller_lfsr16.sv
// 16-bit Galois LFSR that advances one step per cycle when step is high;
// a nonzero seed keeps it off the all-zero lockup state.
module jc_lfsr16
  import jump_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  // LFSR state register with synchronous reload of the seed
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= seed;
    end else if (step) begin
      q <= lfsr_step(q);
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/jump_controller.sv
// Game-logic initiator: turns key pulses into registered jump/fail commands,
// tracks score, the upcoming platform sides and the per-move timeout.
module jump_controller
  import jump_controller_pkg::*;
#(
  parameter int          VISIBLE    = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          TICK_DIV   = 40_000,
  parameter int          TIMEOUT_MS = 2000,
  parameter int          SCORE_MAX  = 9999
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               module_en,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               landed,
  output logic               jump_left,
  output logic               jump_right,
  output logic               jump_fail,
  output logic               scroll,
  output logic [VISIBLE-1:0] block_sides,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  jc_state_t          state_r, state_nxt_s;
  logic [PRESC_W-1:0] presc_r, presc_nxt_s;
  logic [MS_W-1:0]    ms_r, ms_nxt_s;
  logic [SCORE_W-1:0] score_nxt_s;
  logic [VISIBLE-1:0] sides_nxt_s;
  logic [15:0]        lfsr_q_s, lfsr_next_s;
  logic               reset_s, lfsr_step_s, tick_end_s, timeout_s;
  logic               jl_nxt_s, jr_nxt_s, jf_nxt_s, scroll_nxt_s, over_nxt_s;

  assign reset_s     = rst | ~module_en;
  assign lfsr_next_s = lfsr_step(lfsr_q_s);
  assign tick_end_s  = (presc_r == PRESC_W'(TICK_DIV - 1));
  // Timeout fires in the cycle the ms counter would reach TIMEOUT_MS
  assign timeout_s   = tick_end_s && (ms_r == MS_W'(TIMEOUT_MS - 1));

  jc_lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (reset_s),
    .step (lfsr_step_s),
    .seed (LFSR_SEED),
    .q    (lfsr_q_s)
  );

  // Next-state, timer, score and command decode
  always_comb begin
    state_nxt_s  = state_r;
    presc_nxt_s  = presc_r;
    ms_nxt_s     = ms_r;
    score_nxt_s  = score;
    sides_nxt_s  = block_sides;
    over_nxt_s   = game_over;
    lfsr_step_s  = 1'b0;
    jl_nxt_s     = 1'b0;
    jr_nxt_s     = 1'b0;
    jf_nxt_s     = 1'b0;
    scroll_nxt_s = 1'b0;
    case (state_r)
      S_WAIT_KEY: begin
        if (tick_end_s) begin
          presc_nxt_s = '0;
          ms_nxt_s    = ms_r + MS_W'(1);
        end else begin
          presc_nxt_s = presc_r + PRESC_W'(1);
        end
        if (timeout_s || (key_left && key_right)) begin
          jf_nxt_s    = 1'b1;
          state_nxt_s = S_FALL;
        end else if (key_left || key_right) begin
          if ((key_right ? SIDE_RIGHT : SIDE_LEFT) == block_sides[0]) begin
            jl_nxt_s    = key_left;
            jr_nxt_s    = key_right;
            state_nxt_s = S_JUMP;
          end else begin
            jf_nxt_s    = 1'b1;
            state_nxt_s = S_FALL;
          end
        end else begin
          state_nxt_s = S_WAIT_KEY;
        end
      end
      S_JUMP: begin
        if (landed) begin
          if (score < SCORE_W'(SCORE_MAX)) begin
            score_nxt_s = score + SCORE_W'(1);
          end else begin
            score_nxt_s = SCORE_W'(SCORE_MAX);
          end
          lfsr_step_s  = 1'b1;
          sides_nxt_s  = {lfsr_next_s[0], block_sides[VISIBLE-1:1]};
          scroll_nxt_s = 1'b1;
          presc_nxt_s  = '0;
          ms_nxt_s     = '0;
          state_nxt_s  = S_WAIT_KEY;
        end else begin
          state_nxt_s = S_JUMP;
        end
      end
      S_FALL: begin
        if (landed) begin
          over_nxt_s  = 1'b1;
          state_nxt_s = S_OVER;
        end else begin
          state_nxt_s = S_FALL;
        end
      end
      S_OVER: begin
        state_nxt_s = S_OVER;
      end
      default: begin
        state_nxt_s = S_WAIT_KEY;
      end
    endcase
  end

  // State and registered outputs; module_en low acts exactly like rst
  always_ff @(posedge clk) begin
    if (reset_s) begin
      state_r     <= S_WAIT_KEY;
      presc_r     <= '0;
      ms_r        <= '0;
      score       <= '0;
      block_sides <= LFSR_SEED[VISIBLE-1:0];
      game_over   <= 1'b0;
      jump_left   <= 1'b0;
      jump_right  <= 1'b0;
      jump_fail   <= 1'b0;
      scroll      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      presc_r     <= presc_nxt_s;
      ms_r        <= ms_nxt_s;
      score       <= score_nxt_s;
      block_sides <= sides_nxt_s;
      game_over   <= over_nxt_s;
      jump_left   <= jl_nxt_s;
      jump_right  <= jr_nxt_s;
      jump_fail   <= jf_nxt_s;
      scroll      <= scroll_nxt_s;
    end
  end

endmodule

// File: tb/tb_jump_controller.sv
// Self-checking bench for jump_controller: directed scenarios with literal
// expectations plus randomized play checked every cycle against a game model.
module tb_jump_controller;

  localparam int          VIS   = 4;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          TICK  = 4;
  localparam int          TMO   = 3;
  localparam int          SMAX  = 5;

  logic           clk = 1'b0;
  logic           rst, module_en, key_left, key_right, landed;
  logic           jump_left, jump_right, jump_fail, scroll, game_over;
  logic [VIS-1:0] block_sides;
  logic [13:0]    score;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // game model: 0 awaiting key, 1 airborne (good), 2 falling, 3 game over
  int          m_phase, m_wait, m_score;
  logic [15:0] m_lfsr;
  bit          m_sides[$];
  bit          e_jl, e_jr, e_jf, e_scroll, e_over;

  jump_controller #(
    .VISIBLE(VIS), .LFSR_SEED(SEED), .TICK_DIV(TICK), .TIMEOUT_MS(TMO), .SCORE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst), .module_en(module_en), .key_left(key_left),
    .key_right(key_right), .landed(landed), .jump_left(jump_left),
    .jump_right(jump_right), .jump_fail(jump_fail), .scroll(scroll),
    .block_sides(block_sides), .score(score), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] poly_next(input logic [15:0] v);
    logic [15:0] mask;
    mask = 16'((1 << 15) | (1 << 13) | (1 << 12) | (1 << 10));
    return v[0] ? ((v >> 1) ^ mask) : (v >> 1);
  endfunction

  function automatic logic [VIS-1:0] exp_sides();
    logic [VIS-1:0] r;
    for (int i = 0; i < VIS; i++) r[i] = m_sides[i];
    return r;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_wait = 0; m_score = 0; m_lfsr = SEED;
    m_sides.delete();
    for (int i = 0; i < VIS; i++) m_sides.push_back(SEED[i]);
    e_jl = 0; e_jr = 0; e_jf = 0; e_scroll = 0; e_over = 0;
  endtask

  always @(posedge clk) begin
    if (rst || !module_en) begin
      model_reset();
    end else begin
      e_jl = 0; e_jr = 0; e_jf = 0; e_scroll = 0;
      if (m_phase == 0) begin
        if (m_wait == TICK * TMO - 1) begin
          e_jf = 1; m_phase = 2;
        end else begin
          m_wait++;
          if (key_left && key_right) begin
            e_jf = 1; m_phase = 2;
          end else if (key_left || key_right) begin
            if (key_right == m_sides[0]) begin
              e_jl = key_left; e_jr = key_right; m_phase = 1;
            end else begin
              e_jf = 1; m_phase = 2;
            end
          end
        end
      end else if (m_phase == 1) begin
        if (landed) begin
          if (m_score < SMAX) m_score++;
          m_lfsr = poly_next(m_lfsr);
          void'(m_sides.pop_front());
          m_sides.push_back(m_lfsr[0]);
          e_scroll = 1; m_wait = 0; m_phase = 0;
        end
      end else if (m_phase == 2) begin
        if (landed) begin
          e_over = 1; m_phase = 3;
        end
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if ({jump_left, jump_right, jump_fail, scroll, game_over, block_sides, score} !==
          {e_jl, e_jr, e_jf, e_scroll, e_over, exp_sides(), 14'(m_score)}) begin
        n_fail++;
        $display("FAIL model t=%0t got jl=%b jr=%b jf=%b sc=%b go=%b bs=%h score=%0d want jl=%b jr=%b jf=%b sc=%b go=%b bs=%h score=%0d",
                 $time, jump_left, jump_right, jump_fail, scroll, game_over, block_sides, score,
                 e_jl, e_jr, e_jf, e_scroll, e_over, exp_sides(), m_score);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit kl, input bit kr, input bit ld);
    key_left = kl; key_right = kr; landed = ld;
    @(posedge clk); #1;
    key_left = 1'b0; key_right = 1'b0; landed = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    int  first;
    bit  s;
    int  r, k;
    rst = 1'b1; module_en = 1'b1; key_left = 1'b0; key_right = 1'b0; landed = 1'b0;
    model_reset();
    do_reset();
    chk_en = 1'b1;

    // reset state
    check("reset_sides", 32'(block_sides), 32'h1);
    check("reset_score", 32'(score), 32'h0);
    check("reset_cmds", 32'({jump_left, jump_right, jump_fail, scroll, game_over}), 32'h0);

    // correct right jump, land five cycles after the key
    cyc(0, 1, 0);
    check("jr_pulse", 32'({jump_left, jump_right, jump_fail}), 32'h2);
    cyc(0, 0, 0);
    check("jr_one_cycle", 32'(jump_right), 32'h0);
    repeat (3) cyc(0, 0, 0);
    cyc(0, 0, 1);
    check("land_score", 32'(score), 32'h1);
    check("land_scroll", 32'(scroll), 32'h1);
    check("land_sides", 32'(block_sides), 32'h0);
    cyc(0, 0, 0);
    check("scroll_one_cycle", 32'(scroll), 32'h0);

    // wrong key: fall, game over, keys then ignored
    do_reset();
    cyc(1, 0, 0);
    check("wrong_fail", 32'({jump_left, jump_right, jump_fail}), 32'h1);
    cyc(0, 0, 1);
    check("fall_over", 32'(game_over), 32'h1);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    check("over_quiet", 32'({jump_left, jump_right, jump_fail}), 32'h0);
    check("over_held", 32'(game_over), 32'h1);

    // timeout latency
    do_reset();
    first = 0;
    for (int n = 1; n <= 20; n++) begin
      cyc(0, 0, 0);
      if (jump_fail && first == 0) first = n;
    end
    check("timeout_latency", 32'(first), 32'd12);

    // both keys together
    do_reset();
    cyc(1, 1, 0);
    check("both_keys_fail", 32'({jump_left, jump_right, jump_fail}), 32'h1);

    // keys during jump are ignored; landed outside a move is ignored
    do_reset();
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    check("jump_keys_ignored", 32'({jump_left, jump_right, jump_fail}), 32'h0);
    cyc(0, 0, 1);
    check("single_increment", 32'(score), 32'h1);
    cyc(0, 0, 1);
    check("stray_landed", 32'({score, jump_fail}), 32'({14'd1, 1'b0}));

    // score saturation
    do_reset();
    repeat (SMAX + 2) begin
      s = m_sides[0];
      cyc(!s, s, 0);
      cyc(0, 0, 1);
      cyc(0, 0, 0);
    end
    check("score_saturate", 32'(score), 32'(SMAX));

    // module_en low in the middle of a jump
    do_reset();
    s = m_sides[0];
    cyc(!s, s, 0);
    module_en = 1'b0;
    cyc(0, 0, 0);
    check("en_low_cmds", 32'({jump_left, jump_right, jump_fail, scroll, game_over}), 32'h0);
    check("en_low_sides", 32'(block_sides), 32'h1);
    check("en_low_score", 32'(score), 32'h0);
    module_en = 1'b1;

    // randomized play
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      rst = (r == 0);
      module_en = (r != 1);
      k = $urandom_range(0, 9);
      s = m_sides[0];
      if (k < 3)       cyc(!s, s, ($urandom_range(0, 5) == 0));
      else if (k == 3) cyc(s, !s, ($urandom_range(0, 5) == 0));
      else if (k == 4) cyc(1, 1, ($urandom_range(0, 5) == 0));
      else             cyc(0, 0, ($urandom_range(0, 3) == 0));
    end
    rst = 1'b0; module_en = 1'b1;
    cyc(0, 0, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
